btn_cursor_ctrl: RTL and testbench

Converts debounced button codes from the push-button debouncer into the cursor square's position and colour. It drives the `iXRedCounter`, `iYRedCounter` and `iColorCuadro` inputs of the VGA controller. The block adds press-edge detection, hold-to-repeat, saturating X/Y movement and a colour cycle on the centre button.

---
 rtl/btn_cursor_ctrl_pkg.sv | 25 ++
 rtl/btn_repeat_gen.sv | 83 ++++++++
 rtl/btn_cursor_ctrl.sv | 82 ++++++++
 tb/tb_btn_cursor_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/btn_cursor_ctrl_pkg.sv
// Shared definitions for the button-driven cursor controller:
// button bit positions, repeat FSM encoding and reset values.
package btn_cursor_ctrl_pkg;

  localparam int BTN_UP    = 4;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_CNTR  = 0;

  localparam logic [7:0] RESET_POS   = 8'd128;
  localparam logic [2:0] RESET_COLOR = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // Exactly one bit set; zero and multi-hot codes mean "no button".
  function automatic logic is_one_hot(input logic [4:0] code);
    return (code != 5'd0) && ((code & (code - 5'd1)) == 5'd0);
  endfunction

endpackage

// File: rtl/btn_repeat_gen.sv
// Registers the button code and turns presses and long holds into a
// one-cycle event strobe with the code that caused it.
module btn_repeat_gen
  import btn_cursor_ctrl_pkg::*;
#(
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [4:0] iBTN,
  output logic       oEvent,
  output logic [4:0] oCode
);

  localparam int MAX_CYC = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

  logic [4:0]       rBtn;
  logic [4:0]       rBtnPrev;
  logic [CNT_W-1:0] count_reg;
  rep_state_t       state_reg;

  logic valid;
  logic changed;
  logic expired;

  assign valid   = is_one_hot(rBtn);
  assign changed = (rBtn != rBtnPrev);
  // The centre button never repeats, so its frozen counter can never expire.
  assign expired = (count_reg == '0) && !rBtn[BTN_CNTR];

  always_comb begin
    oEvent = 1'b0;
    case (state_reg)
      IDLE:         oEvent = valid;
      HOLD, REPEAT: oEvent = valid && (changed || expired);
      default:      oEvent = 1'b0;
    endcase
  end

  assign oCode = rBtn;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rBtn      <= '0;
      rBtnPrev  <= '0;
      count_reg <= '0;
      state_reg <= IDLE;
    end else begin
      rBtnPrev <= rBtn;
      rBtn     <= iBTN;
      case (state_reg)
        IDLE: begin
          if (valid) begin
            count_reg <= DELAY_LOAD;
            state_reg <= HOLD;
          end
        end
        HOLD, REPEAT: begin
          // rBtnPrev equals the held code whenever we are in HOLD or REPEAT.
          if (!valid) begin
            state_reg <= IDLE;
          end else if (changed) begin
            count_reg <= DELAY_LOAD;
            state_reg <= HOLD;
          end else if (rBtn[BTN_CNTR]) begin
            count_reg <= count_reg;
          end else if (count_reg == '0) begin
            count_reg <= PERIOD_LOAD;
            state_reg <= REPEAT;
          end else begin
            count_reg <= count_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/btn_cursor_ctrl.sv
// Cursor position and colour for the VGA controller, driven by debounced
// buttons with press detection, hold-to-repeat and saturating moves.
module btn_cursor_ctrl
  import btn_cursor_ctrl_pkg::*;
#(
  parameter int STEP          = 8,
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [4:0] iBTN,
  output logic [7:0] oXRedCounter,
  output logic [7:0] oYRedCounter,
  output logic [2:0] oColorCuadro,
  output logic       oMoved
);

  localparam logic [8:0] MAX_POS = 9'(256 - STEP);

  logic       ev;
  logic [4:0] ev_code;
  logic [7:0] x_next;
  logic [7:0] y_next;
  logic [2:0] color_next;
  logic       moved_next;

  btn_repeat_gen #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_repeat (
    .Clock  (Clock),
    .Reset  (Reset),
    .iBTN   (iBTN),
    .oEvent (ev),
    .oCode  (ev_code)
  );

  // A borrow out of the 9-bit subtraction means we went below zero.
  function automatic logic [7:0] step_dec(input logic [7:0] pos);
    logic [8:0] d;
    d = {1'b0, pos} - 9'(STEP);
    return d[8] ? 8'd0 : d[7:0];
  endfunction

  function automatic logic [7:0] step_inc(input logic [7:0] pos);
    logic [8:0] s;
    s = {1'b0, pos} + 9'(STEP);
    return (s > MAX_POS) ? MAX_POS[7:0] : s[7:0];
  endfunction

  always_comb begin
    x_next     = oXRedCounter;
    y_next     = oYRedCounter;
    color_next = oColorCuadro;
    if (ev) begin
      if (ev_code[BTN_UP])         y_next = step_dec(oYRedCounter);
      else if (ev_code[BTN_DOWN])  y_next = step_inc(oYRedCounter);
      else if (ev_code[BTN_LEFT])  x_next = step_dec(oXRedCounter);
      else if (ev_code[BTN_RIGHT]) x_next = step_inc(oXRedCounter);
      else if (ev_code[BTN_CNTR])
        color_next = (oColorCuadro == 3'b111) ? 3'b001 : oColorCuadro + 3'd1;
    end
    moved_next = (x_next != oXRedCounter) || (y_next != oYRedCounter) ||
                 (color_next != oColorCuadro);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      oXRedCounter <= RESET_POS;
      oYRedCounter <= RESET_POS;
      oColorCuadro <= RESET_COLOR;
      oMoved       <= 1'b0;
    end else begin
      oXRedCounter <= x_next;
      oYRedCounter <= y_next;
      oColorCuadro <= color_next;
      oMoved       <= moved_next;
    end
  end

endmodule

// File: tb/tb_btn_cursor_ctrl.sv
// Directed bench for btn_cursor_ctrl with STEP=8, REPEAT_DELAY=10, REPEAT_PERIOD=4.
module tb_btn_cursor_ctrl;

  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_UP    = 5'b10000;
  localparam logic [4:0] B_DOWN  = 5'b01000;
  localparam logic [4:0] B_LEFT  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b00010;
  localparam logic [4:0] B_CNTR  = 5'b00001;

  logic       Clock;
  logic       Reset;
  logic [4:0] iBTN;
  logic [7:0] oXRedCounter;
  logic [7:0] oYRedCounter;
  logic [2:0] oColorCuadro;
  logic       oMoved;

  int compared   = 0;
  int mismatched = 0;
  int moved_cnt  = 0;
  bit zero_seen  = 1'b0;
  int m0;

  btn_cursor_ctrl #(
    .STEP          (8),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (4)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iBTN         (iBTN),
    .oXRedCounter (oXRedCounter),
    .oYRedCounter (oYRedCounter),
    .oColorCuadro (oColorCuadro),
    .oMoved       (oMoved)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    #1;
    if (!Reset && oMoved === 1'b1) moved_cnt++;
    if (!Reset && oColorCuadro === 3'b000) zero_seen = 1'b1;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    iBTN  = B_NONE;
    wait_n(3);
    Reset = 1'b0;
    m0 = moved_cnt;
    wait_n(20);
    compared++; if (oXRedCounter !== 8'd128) begin mismatched++; $display("FAIL reset_x: got %0d expected 128", oXRedCounter); end
    compared++; if (oYRedCounter !== 8'd128) begin mismatched++; $display("FAIL reset_y: got %0d expected 128", oYRedCounter); end
    compared++; if (oColorCuadro !== 3'b100) begin mismatched++; $display("FAIL reset_color: got %b expected 100", oColorCuadro); end
    compared++; if (moved_cnt - m0 !== 0) begin mismatched++; $display("FAIL reset_moved: got %0d pulses expected 0", moved_cnt - m0); end
    $display("test_reset: X=%0d Y=%0d C=%b", oXRedCounter, oYRedCounter, oColorCuadro);
  endtask

  task automatic test_tap_right;
    iBTN = B_RIGHT;
    m0 = moved_cnt;
    wait_n(1);
    compared++; if (oXRedCounter !== 8'd128) begin mismatched++; $display("FAIL tap_early: got %0d expected 128", oXRedCounter); end
    wait_n(1);
    compared++; if (oXRedCounter !== 8'd136) begin mismatched++; $display("FAIL tap_x: got %0d expected 136", oXRedCounter); end
    compared++; if (oMoved !== 1'b1) begin mismatched++; $display("FAIL tap_pulse: got %b expected 1", oMoved); end
    wait_n(1);
    iBTN = B_NONE;
    wait_n(5);
    compared++; if (oYRedCounter !== 8'd128) begin mismatched++; $display("FAIL tap_y: got %0d expected 128", oYRedCounter); end
    compared++; if (moved_cnt - m0 !== 1) begin mismatched++; $display("FAIL tap_pulses: got %0d expected 1", moved_cnt - m0); end
    $display("test_tap_right: X=%0d Y=%0d", oXRedCounter, oYRedCounter);
  endtask

  task automatic test_hold_up;
    logic [7:0] exp_y;
    iBTN = B_UP;
    m0 = moved_cnt;
    wait_n(2);
    compared++; if (oYRedCounter !== 8'd120) begin mismatched++; $display("FAIL hold_press: got %0d expected 120", oYRedCounter); end
    wait_n(9);
    compared++; if (oYRedCounter !== 8'd120) begin mismatched++; $display("FAIL hold_early_repeat: got %0d expected 120 at +9", oYRedCounter); end
    wait_n(1);
    compared++; if (oYRedCounter !== 8'd112) begin mismatched++; $display("FAIL hold_first_repeat: got %0d expected 112 at +10", oYRedCounter); end
    for (int i = 2; i <= 6; i++) begin
      wait_n(4);
      exp_y = 8'(120 - 8 * i);
      compared++; if (oYRedCounter !== exp_y) begin mismatched++; $display("FAIL hold_repeat%0d: got %0d expected %0d", i, oYRedCounter, exp_y); end
    end
    iBTN = B_NONE;
    wait_n(10);
    compared++; if (oYRedCounter !== 8'd72) begin mismatched++; $display("FAIL hold_release: got %0d expected 72", oYRedCounter); end
    compared++; if (moved_cnt - m0 !== 7) begin mismatched++; $display("FAIL hold_pulses: got %0d expected 7", moved_cnt - m0); end
    $display("test_hold_up: Y=%0d pulses=%0d", oYRedCounter, moved_cnt - m0);
  endtask

  task automatic test_left_saturate;
    iBTN = B_LEFT;
    m0 = moved_cnt;
    wait_n(2);
    compared++; if (oXRedCounter !== 8'd128) begin mismatched++; $display("FAIL left_press: got %0d expected 128", oXRedCounter); end
    wait_n(66);
    compared++; if (oXRedCounter !== 8'd8) begin mismatched++; $display("FAIL left_at8: got %0d expected 8", oXRedCounter); end
    wait_n(4);
    compared++; if (oXRedCounter !== 8'd0) begin mismatched++; $display("FAIL left_at0: got %0d expected 0", oXRedCounter); end
    compared++; if (oMoved !== 1'b1) begin mismatched++; $display("FAIL left_last_pulse: got %b expected 1", oMoved); end
    wait_n(4);
    compared++; if (oXRedCounter !== 8'd0) begin mismatched++; $display("FAIL left_sat: got %0d expected 0", oXRedCounter); end
    compared++; if (oMoved !== 1'b0) begin mismatched++; $display("FAIL left_sat_pulse: got %b expected 0", oMoved); end
    wait_n(16);
    iBTN = B_NONE;
    wait_n(8);
    compared++; if (moved_cnt - m0 !== 17) begin mismatched++; $display("FAIL left_pulses: got %0d expected 17", moved_cnt - m0); end
    $display("test_left_saturate: X=%0d pulses=%0d", oXRedCounter, moved_cnt - m0);
  endtask

  task automatic test_cntr;
    logic [2:0] exp_c [8];
    exp_c = '{3'b101, 3'b110, 3'b111, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    for (int i = 0; i < 8; i++) begin
      iBTN = B_CNTR;
      wait_n(2);
      compared++; if (oColorCuadro !== exp_c[i]) begin mismatched++; $display("FAIL cntr_press%0d: got %b expected %b", i, oColorCuadro, exp_c[i]); end
      $display("test_cntr: press %0d C=%b", i, oColorCuadro);
      wait_n(1);
      iBTN = B_NONE;
      wait_n(3);
    end
    iBTN = B_CNTR;
    m0 = moved_cnt;
    wait_n(50);
    iBTN = B_NONE;
    wait_n(4);
    compared++; if (oColorCuadro !== 3'b110) begin mismatched++; $display("FAIL cntr_hold_color: got %b expected 110", oColorCuadro); end
    compared++; if (moved_cnt - m0 !== 1) begin mismatched++; $display("FAIL cntr_hold_pulses: got %0d expected 1", moved_cnt - m0); end
    $display("test_cntr: hold C=%b pulses=%0d", oColorCuadro, moved_cnt - m0);
  endtask

  task automatic test_switch_reset;
    iBTN = B_DOWN;
    wait_n(2);
    compared++; if (oYRedCounter !== 8'd80) begin mismatched++; $display("FAIL switch_down: got %0d expected 80", oYRedCounter); end
    wait_n(3);
    iBTN = B_RIGHT;
    wait_n(2);
    compared++; if (oXRedCounter !== 8'd8) begin mismatched++; $display("FAIL switch_right: got %0d expected 8", oXRedCounter); end
    compared++; if (oYRedCounter !== 8'd80) begin mismatched++; $display("FAIL switch_y: got %0d expected 80", oYRedCounter); end
    wait_n(2);
    iBTN = B_UP | B_LEFT;
    m0 = moved_cnt;
    wait_n(15);
    compared++; if (oXRedCounter !== 8'd8 || oYRedCounter !== 8'd80) begin mismatched++; $display("FAIL multihot_pos: got X=%0d Y=%0d expected X=8 Y=80", oXRedCounter, oYRedCounter); end
    compared++; if (moved_cnt - m0 !== 0) begin mismatched++; $display("FAIL multihot_pulses: got %0d expected 0", moved_cnt - m0); end
    iBTN = B_DOWN;
    wait_n(2);
    compared++; if (oYRedCounter !== 8'd88) begin mismatched++; $display("FAIL repress_down: got %0d expected 88", oYRedCounter); end
    wait_n(4);
    Reset = 1'b1;
    wait_n(1);
    compared++; if (oXRedCounter !== 8'd128 || oYRedCounter !== 8'd128) begin mismatched++; $display("FAIL midreset_pos: got X=%0d Y=%0d expected 128/128", oXRedCounter, oYRedCounter); end
    compared++; if (oColorCuadro !== 3'b100) begin mismatched++; $display("FAIL midreset_color: got %b expected 100", oColorCuadro); end
    compared++; if (oMoved !== 1'b0) begin mismatched++; $display("FAIL midreset_moved: got %b expected 0", oMoved); end
    wait_n(2);
    Reset = 1'b0;
    wait_n(1);
    compared++; if (oYRedCounter !== 8'd128) begin mismatched++; $display("FAIL post_reset_early: got %0d expected 128", oYRedCounter); end
    wait_n(1);
    compared++; if (oYRedCounter !== 8'd136) begin mismatched++; $display("FAIL post_reset_press: got %0d expected 136", oYRedCounter); end
    compared++; if (oMoved !== 1'b1) begin mismatched++; $display("FAIL post_reset_pulse: got %b expected 1", oMoved); end
    iBTN = B_NONE;
    wait_n(5);
    $display("test_switch_reset: X=%0d Y=%0d C=%b", oXRedCounter, oYRedCounter, oColorCuadro);
  endtask

  initial begin
    Reset = 1'b1;
    iBTN  = B_NONE;
    test_reset();
    test_tap_right();
    test_hold_up();
    test_left_saturate();
    test_cntr();
    test_switch_reset();
    compared++; if (zero_seen) begin mismatched++; $display("FAIL color_zero: got 000 at some point expected never"); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
